// File: rtl/rotary_pkg.sv
// Shared constants, quadrature state encoding and Gray-order helper
// for the rotary encoder decoder.
package rotary_pkg;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  localparam logic [1:0] DETENT_DEFAULT = 2'b11;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

  typedef logic signed [3:0] substep_t;
  localparam substep_t SUBSTEP_THRESHOLD = 4'sd4;

  typedef enum logic [1:0] {
    QD_00 = 2'b00,
    QD_01 = 2'b01,
    QD_10 = 2'b10,
    QD_11 = 2'b11
  } quad_t;

  // Clockwise successor in the sequence 11 -> 10 -> 00 -> 01 -> 11.
  function automatic quad_t cw_next(input quad_t q);
    quad_t r;
    case (q)
      QD_11:   r = QD_10;
      QD_10:   r = QD_00;
      QD_00:   r = QD_01;
      default: r = QD_11;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade digit (0..9) with increment/decrement and wrap-around;
// carry/borrow flag the 9->0 and 0->9 transitions for the next digit.
module bcd_digit
  import rotary_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] value,
  output logic       carry,
  output logic       borrow
);

  assign carry  = inc && (value == BCD_MAX_DIGIT);
  assign borrow = dec && !inc && (value == 4'd0);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      value <= 4'd0;
    end else if (inc) begin
      value <= carry ? 4'd0 : value + 4'd1;
    end else if (dec) begin
      value <= borrow ? BCD_MAX_DIGIT : value - 4'd1;
    end
  end

endmodule

// File: rtl/rotary_decoder.sv
// Debounced quadrature decoder: per-phase glitch filters feed a
// detent-to-detent step FSM that drives a two-digit BCD position count.
//
// state (prev {A,B}) | meaning
// -------------------+-------------------------------------------
// DETENT (def 11)    | encoder at rest; sub-step count evaluated, cleared
// 10                 | CW phase 1 / CCW phase 3
// 00                 | half-way between detents
// 01                 | CW phase 3 / CCW phase 1
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int         STABLE_CYCLES = 4,
  parameter logic [1:0] DETENT        = DETENT_DEFAULT
) (
  input  logic       C,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  output logic       step,
  output logic       dir,
  output logic       err,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [1:0]      raw;
  logic [1:0]      filt, filt_nxt;
  logic [1:0][7:0] cnt, cnt_nxt;

  quad_t    cur, prev, prev_nxt;
  substep_t sub, sub_nxt, moved;
  logic     step_nxt, dir_nxt, err_nxt;

  logic ones_carry, ones_borrow;
  logic tens_carry_unused, tens_borrow_unused;

  assign raw = {A, B};
  assign cur = quad_t'(filt);

  // The filtered bit flips on the STABLE_CYCLES-th consecutive mismatch.
  always_comb begin
    filt_nxt = filt;
    cnt_nxt  = cnt;
    for (int i = 0; i < 2; i++) begin
      if (raw[i] != filt[i]) begin
        if (cnt[i] == CNT_LAST) begin
          filt_nxt[i] = raw[i];
          cnt_nxt[i]  = 8'd0;
        end else begin
          cnt_nxt[i] = cnt[i] + 8'd1;
        end
      end else begin
        cnt_nxt[i] = 8'd0;
      end
    end
  end

  always_comb begin
    prev_nxt = prev;
    sub_nxt  = sub;
    moved    = sub;
    step_nxt = 1'b0;
    err_nxt  = 1'b0;
    dir_nxt  = dir;
    if (cur != prev) begin
      prev_nxt = cur;
      if ((filt ^ prev) == 2'b11) begin
        err_nxt = 1'b1;
        sub_nxt = '0;
      end else begin
        if (cw_next(prev) == cur) begin
          moved = (sub == SUBSTEP_THRESHOLD) ? sub : substep_t'(sub + 4'sd1);
        end else begin
          moved = (sub == -SUBSTEP_THRESHOLD) ? sub : substep_t'(sub - 4'sd1);
        end
        if (cur == quad_t'(DETENT)) begin
          sub_nxt = '0;
          if (moved == SUBSTEP_THRESHOLD) begin
            step_nxt = 1'b1;
            dir_nxt  = DIR_CW;
          end else if (moved == -SUBSTEP_THRESHOLD) begin
            step_nxt = 1'b1;
            dir_nxt  = DIR_CCW;
          end
        end else begin
          sub_nxt = moved;
        end
      end
    end
  end

  always_ff @(posedge C) begin
    if (reset) begin
      filt <= DETENT;
      cnt  <= '0;
      prev <= quad_t'(DETENT);
      sub  <= '0;
      step <= 1'b0;
      err  <= 1'b0;
      dir  <= 1'b0;
    end else begin
      filt <= filt_nxt;
      cnt  <= cnt_nxt;
      prev <= prev_nxt;
      sub  <= sub_nxt;
      step <= step_nxt;
      err  <= err_nxt;
      dir  <= dir_nxt;
    end
  end

  // Digits advance on the same edge that registers step.
  bcd_digit u_ones (
    .clk_sys (C),
    .reset   (reset),
    .inc     (step_nxt && (dir_nxt == DIR_CW)),
    .dec     (step_nxt && (dir_nxt == DIR_CCW)),
    .value   (bcd_ones),
    .carry   (ones_carry),
    .borrow  (ones_borrow)
  );

  bcd_digit u_tens (
    .clk_sys (C),
    .reset   (reset),
    .inc     (ones_carry),
    .dec     (ones_borrow),
    .value   (bcd_tens),
    .carry   (tens_carry_unused),
    .borrow  (tens_borrow_unused)
  );

endmodule
